arcade_input_map: RTL and testbench

ARCADE_INPUT_MAP -- requirements
Module: arcade_input_map

---
 rtl/arcade_input_map_if.sv | 10 +
 rtl/arcade_input_map.sv | 126 ++++++++++++
 tb/tb_arcade_input_map.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_map_if.sv
// rtl/arcade_input_map_if.sv - hps_io download bus bundle feeding the DIP switch banks
interface arcade_input_map_if;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    modport master (output ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
    modport slave  (input  ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/arcade_input_map.sv
// rtl/arcade_input_map.sv - joystick/coin/service/DIP mapping to active-low arcade inputs
// Optional autofire on joystick bit9 when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_map #(
    parameter int NUM_PLAYERS       = 2,
    parameter int DIP_BANKS         = 2,
    parameter int COIN_PULSE_CYCLES = 5360000,
    parameter int AUTOFIRE_HALF     = 1787000
) (
    input  logic                      i_clk,
    input  logic                      reset,
    input  logic [16*NUM_PLAYERS-1:0] joystick_i,
    input  logic                      service_i,
    arcade_input_map_if.slave         ioctl,
    output logic [16*NUM_PLAYERS-1:0] player_o,
    output logic [8*DIP_BANKS-1:0]    dsw_o,
    output logic                      dip_valid_o
);
    localparam int CW = $clog2(COIN_PULSE_CYCLES + 1);

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [15:0]   joy;
        logic [15:0]   word_q;
        logic          coin_q;
        logic          coin_prev;
        logic          coin_armed;
        logic          coin_rise;
        logic [CW-1:0] coin_cnt;
        logic [CW-1:0] coin_cnt_nxt;
        logic          up, down, left, right;
        logic          af_fire;
        logic          fire_act;
        logic          unused_bits;

        assign joy         = joystick_i[16*p +: 16];
        assign unused_bits = &{1'b0, joy[15:10]};

        // Opposing directions pressed together cancel each other out.
        always_comb begin
            up           = joy[3] & ~joy[2];
            down         = joy[2] & ~joy[3];
            left         = joy[1] & ~joy[0];
            right        = joy[0] & ~joy[1];
            fire_act     = joy[4] | af_fire;
            coin_rise    = coin_q & ~coin_prev & coin_armed;
            coin_cnt_nxt = coin_cnt;
            if (coin_cnt != '0)
                coin_cnt_nxt = coin_cnt - CW'(1);
            else if (coin_rise)
                coin_cnt_nxt = CW'(COIN_PULSE_CYCLES);
        end

        // coin_armed blocks a coin still held from before reset until it is let go.
        always_ff @(posedge i_clk or posedge reset) begin
            if (reset) begin
                coin_q     <= 1'b0;
                coin_prev  <= 1'b0;
                coin_armed <= 1'b0;
                coin_cnt   <= '0;
                word_q     <= 16'hFFFF;
            end else begin
                coin_q     <= joy[8];
                coin_prev  <= coin_q;
                coin_armed <= coin_armed | ~joy[8];
                coin_cnt   <= coin_cnt_nxt;
                word_q     <= {2'b11, ~up, ~down, ~right, ~left, ~service_i, 4'b1111,
                               ~joy[6], ~joy[5], ~fire_act, ~joy[7], ~(coin_cnt_nxt != '0)};
            end
        end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
        localparam int AW = $clog2(AUTOFIRE_HALF + 1);
        logic          af_q;
        logic          af_phase;
        logic [AW-1:0] af_cnt;

        always_ff @(posedge i_clk or posedge reset) begin
            if (reset) begin
                af_q     <= 1'b0;
                af_phase <= 1'b1;
                af_cnt   <= '0;
            end else begin
                af_q <= joy[9];
                if (!af_q) begin
                    af_phase <= 1'b1;
                    af_cnt   <= '0;
                end else if (af_cnt == AW'(AUTOFIRE_HALF - 1)) begin
                    af_phase <= ~af_phase;
                    af_cnt   <= '0;
                end else begin
                    af_cnt <= af_cnt + AW'(1);
                end
            end
        end

        assign af_fire = af_q & af_phase;
`else
        logic unused_af;
        assign unused_af = joy[9];
        assign af_fire   = 1'b0;
`endif

        assign player_o[16*p +: 16] = word_q;
    end

    // DIP banks are configuration from the loader, so they survive reset.
    logic [8*DIP_BANKS-1:0] dsw_q       = '1;
    logic                   dip_valid_q = 1'b0;
    logic                   dip_hit;

    assign dip_hit = ioctl.ioctl_wr && (ioctl.ioctl_index == 8'd254) &&
                     (ioctl.ioctl_addr[24:3] == '0);

    always_ff @(posedge i_clk) begin
        if (dip_hit) begin
            for (int b = 0; b < DIP_BANKS; b++) begin
                if (ioctl.ioctl_addr[2:0] == 3'(b))
                    dsw_q[8*b +: 8] <= ~ioctl.ioctl_dout;
            end
            if (ioctl.ioctl_addr[2:0] == 3'd0)
                dip_valid_q <= 1'b1;
        end
    end

    assign dsw_o       = dsw_q;
    assign dip_valid_o = dip_valid_q;
endmodule

// File: tb/tb_arcade_input_map.sv
// tb/tb_arcade_input_map.sv - self-checking bench for arcade_input_map
module tb_arcade_input_map;
    localparam int NP = 2;
    localparam int DB = 2;
    localparam int CP = 8;
    localparam int AH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] joy;
    logic        svc;
    logic [31:0] player;
    logic [15:0] dsw;
    logic        dip_valid;

    arcade_input_map_if ioctl();

    arcade_input_map #(
        .NUM_PLAYERS(NP), .DIP_BANKS(DB), .COIN_PULSE_CYCLES(CP), .AUTOFIRE_HALF(AH)
    ) dut (
        .i_clk(clk), .reset(rst), .joystick_i(joy), .service_i(svc), .ioctl(ioctl),
        .player_o(player), .dsw_o(dsw), .dip_valid_o(dip_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] joy;
        logic        svc;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Inputs are already set; queue the expectation, clock once, compare after the edge.
    task automatic cycle_check(input string name, input logic [31:0] mask, input logic [31:0] expv);
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        check(name, player & mask, exp_q.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dip_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d);
        ioctl.ioctl_wr    = 1'b1;
        ioctl.ioctl_index = idx;
        ioctl.ioctl_addr  = addr;
        ioctl.ioctl_dout  = d;
        @(posedge clk);
        #1;
        ioctl.ioctl_wr = 1'b0;
    endtask

    initial begin
        logic [31:0] e;
        logic        cin;

        vecs[0] = '{32'h0000_0019, 1'b0, 32'hFFFF_D7FB};
        vecs[1] = '{32'h000E_0000, 1'b0, 32'hFBFF_FFFF};
        vecs[2] = '{32'h00F0_0007, 1'b0, 32'hFFE1_EFFF};
        vecs[3] = '{32'h0000_0000, 1'b1, 32'hFDFF_FDFF};
        vecs[4] = '{32'h000A_000F, 1'b0, 32'hDBFF_FFFF};
        vecs[5] = '{32'h0001_FC00, 1'b0, 32'hF7FF_FFFF};

        rst = 1'b1;
        joy = '0;
        svc = 1'b0;
        ioctl.ioctl_wr    = 1'b0;
        ioctl.ioctl_index = '0;
        ioctl.ioctl_addr  = '0;
        ioctl.ioctl_dout  = '0;
        #1;
        check("reset_player", player, 32'hFFFF_FFFF);
        check("powerup_dsw", {16'h0, dsw}, 32'h0000_FFFF);
        check("powerup_dip_valid", {31'h0, dip_valid}, 32'h0);
        idle(2);
        rst = 1'b0;
        idle(3);

        for (int i = 0; i < 6; i++) begin
            joy = vecs[i].joy;
            svc = vecs[i].svc;
            cycle_check($sformatf("vec%0d", i), 32'hFFFF_FFFF, vecs[i].exp);
        end
        joy = '0;
        svc = 1'b0;
        idle(3);

        // Coin held for 40 cycles: one pulse only.
        for (int i = 0; i < 40; i++) begin
            joy = 32'h0000_0100;
            e = (i >= 1 && i <= CP) ? 32'h0 : 32'h1;
            cycle_check($sformatf("coin_hold_%0d", i), 32'h1, e);
        end
        joy = '0;
        idle(3);

        // Re-press during the pulse, hold across its end, then a genuine second coin.
        for (int i = 0; i < 46; i++) begin
            cin = !(i == 3 || i == 25 || i == 26);
            joy = {23'h0, cin, 8'h0};
            e = ((i >= 1 && i <= CP) || (i >= 28 && i <= 27 + CP)) ? 32'h0 : 32'h1;
            cycle_check($sformatf("coin_repress_%0d", i), 32'h1, e);
        end
        joy = '0;
        idle(3);

        // Reset mid-pulse aborts it; the held coin must not fire after release.
        joy = 32'h0000_0100;
        idle(4);
        check("coin_mid_pulse_low", player & 32'h1, 32'h0);
        rst = 1'b1;
        #1;
        check("reset_async_player", player, 32'hFFFF_FFFF);
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 15; i++)
            cycle_check($sformatf("coin_held_after_reset_%0d", i), 32'h1, 32'h1);
        joy = '0;
        idle(2);
        for (int i = 0; i < 12; i++) begin
            joy = 32'h0000_0100;
            e = (i >= 1 && i <= CP) ? 32'h0 : 32'h1;
            cycle_check($sformatf("coin_after_rearm_%0d", i), 32'h1, e);
        end
        joy = '0;
        idle(3);

        // DIP switch banks.
        dip_write(8'd254, 25'd1, 8'hA5);
        check("dip_bank1", {16'h0, dsw}, 32'h0000_5AFF);
        check("dip_valid_bank1", {31'h0, dip_valid}, 32'h0);
        dip_write(8'd254, 25'd5, 8'hFF);
        check("dip_oob_bank", {16'h0, dsw}, 32'h0000_5AFF);
        dip_write(8'd253, 25'd0, 8'h11);
        check("dip_wrong_index", {16'h0, dsw}, 32'h0000_5AFF);
        dip_write(8'd254, 25'd8, 8'h22);
        check("dip_high_addr", {16'h0, dsw}, 32'h0000_5AFF);
        check("dip_valid_still_low", {31'h0, dip_valid}, 32'h0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("dip_survives_reset", {16'h0, dsw}, 32'h0000_5AFF);
        dip_write(8'd254, 25'd0, 8'h3C);
        check("dip_bank0", {16'h0, dsw}, 32'h0000_5AC3);
        check("dip_valid_set", {31'h0, dip_valid}, 32'h1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("dip_valid_survives_reset", {31'h0, dip_valid}, 32'h1);
        idle(3);

        // Autofire on player 1 (fire at bit 18 of player_o).
        for (int i = 0; i < 20; i++) begin
            joy = 32'h0200_0000;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            e = (i == 0) ? 32'h0004_0000 :
                ((((i - 1) / AH) % 2) == 0) ? 32'h0 : 32'h0004_0000;
`else
            e = 32'h0004_0000;
`endif
            cycle_check($sformatf("autofire_%0d", i), 32'h0004_0000, e);
        end
        joy = '0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
